mbox_mem_rq_arb: RTL and testbench
==================================

# mbox_mem_rq_arb

Memory request arbiter and sequencer for the MBOX S-bus port. It shares the single memory port between three requesters: the channel (CCL/CRC), the cache sweep writeback (CCA), and the EBOX cache cycle. It issues the start/read/write request with the quadword word mask, counts ACKN pulses word by word, and supplies the MB word-select. It runs the non-existent-memory (NXM) timeout and fabricates the remaining acknowledgements when memory never answers. It feeds the MBZ-side CORE BUSY, NXM and error-hold logic and replaces the ad-hoc MEM START A/B generation.

## Interface
Parameters:
- NXM_TIMEOUT, 255: cycles without ACKN_PULSE, counted from entering WAIT, before NXM is declared. Legal range 2..255.

Ports (index 0 = CHAN, 1 = CCA, 2 = EBOX):
- clk  in  1  MBOX clock. Single clock domain.
- RESET  in  1  Synchronous, active-high reset.
- RQ  in  [0:2]  Request. The requester holds it high until its DONE bit pulses.
- RQ_RD  in  [0:2]  1 = read, 0 = write. Stable while RQ is high.
- RQ_WDS  in  [0:11]  Word masks, 4 bits per requester. Bits [4i:4i+3] are words 0..3.
- ACKN_PULSE  in  1  One-cycle memory acknowledge for one word.
- NXM_ERR_CLR  in  1  Clears the sticky NXM_ERR.
- GRANT  out  [0:2]  One-hot. Held for the whole transaction.
- MEM_START  out  1  Memory start.
- MEM_RD_RQ, MEM_WR_RQ  out  1 each  Direction of the granted transaction.
- MEM_WDS  out  [0:3]  Latched word mask of the granted request.
- MB_SEL  out  [0:1]  Index of the word currently expected.
- WORD_ACK  out  1  Real or fabricated acknowledge of one word.
- NXM_DATA_VAL  out  1  Fabricated read-word strobe during NXM. Read data is to be forced to zero.
- CORE_BUSY  out  1  High from GRANT through the DONE cycle.
- NXM_FLG  out  1  High while in the NXM state.
- NXM_ERR  out  1  Sticky NXM error.
- DONE  out  [0:2]  One-cycle completion pulse to the granted requester.

## Operation
- State machine: IDLE → START → WAIT → (NXM) → FIN → IDLE.
- IDLE:
  - Any RQ high → latch the winner's RD and WDS, set GRANT, go to START.
  - Priority is fixed: CHAN > CCA > EBOX.
  - A WDS of 0000 is latched as 1000.
- START (1 cycle): MEM_START=1, CORE_BUSY=1. MEM_RD_RQ or MEM_WR_RQ follows the latched RD. Go to WAIT; the timeout counter loads 0.
- WAIT:
  - MEM_START stays high until the first ACKN_PULSE is accepted, then drops.
  - Each ACKN_PULSE:
    - pulses WORD_ACK for the word at MB_SEL;
    - clears that bit in the remaining mask;
    - advances MB_SEL to the lowest remaining set bit (ascending order);
    - resets the timeout counter.
  - After the last word is acknowledged → FIN.
  - Counter reaches NXM_TIMEOUT → NXM.
  - ACKN_PULSE and the timeout in the same cycle: the ACKN wins and the counter resets.
- NXM:
  - NXM_FLG=1 and MEM_START=0.
  - Each cycle, one remaining word is retired: WORD_ACK=1, and NXM_DATA_VAL=1 if the transaction is a read. MB_SEL advances as in WAIT.
  - Any ACKN_PULSE is ignored.
  - After the last word → FIN.
  - On entry, NXM_ERR is set.
- FIN (1 cycle): DONE[g]=1, CORE_BUSY=1. Then GRANT clears and the state returns to IDLE.
  - Gap between back-to-back transactions: IDLE for one cycle minimum. A request already waiting is granted in that IDLE cycle.
- NXM_ERR is sticky until NXM_ERR_CLR. Setting and clearing in the same cycle: set wins.
- ACKN_PULSE in IDLE, START or FIN is ignored, with no side effects.
- RQ dropping before DONE is a protocol error. The transaction completes anyway; the DONE pulse is still issued.

## Timing
- Reset: every output is 0 and the state is IDLE. This holds for reset asserted mid-transaction: no DONE pulse, NXM_ERR cleared, counter cleared. Requests are sampled again from the first cycle after RESET falls.
- All outputs are registered. The only combinational paths are ACKN_PULSE → WORD_ACK and ACKN_PULSE → MB_SEL advance, and both are registered one cycle later. WORD_ACK is asserted in the cycle after the ACKN_PULSE it answers. MB_SEL updates in that same cycle.
- Latencies:
  - RQ rising (in IDLE) at cycle n → GRANT and MEM_START at n+1.
  - Final ACKN at cycle m → WORD_ACK at m+1, DONE at m+2. DONE and CORE_BUSY drop at m+3.
  - NXM entered when the counter reaches NXM_TIMEOUT with no ACKN. k remaining words → k WORD_ACK cycles, then one FIN cycle.
- Timeout counter: 8 bits and saturating. It must never wrap while in WAIT.

## Test plan
- Single EBOX read, WDS=1111, ACKN every 3 cycles → MEM_START high from cycle 1 until the first ACKN. WORD_ACK ×4 with MB_SEL 0,1,2,3. DONE[2] 2 cycles after the 4th ACKN. NXM_ERR=0.
- CHAN and EBOX request in the same cycle, CHAN WDS=0101 write → GRANT=100 and MEM_WR_RQ=1. MB_SEL goes 1 then 3. After DONE[0], EBOX is granted after exactly one IDLE cycle.
- NXM_TIMEOUT=8, CCA read WDS=0011, no ACKN → NXM_FLG set 8 cycles after entering WAIT. Two WORD_ACK+NXM_DATA_VAL cycles with MB_SEL 2,3. DONE[1] follows. NXM_ERR stays 1 until NXM_ERR_CLR.
- ACKN_PULSE on the exact cycle the counter hits NXM_TIMEOUT → no NXM. The word is acknowledged and the counter restarts from 0.
- RESET asserted in WAIT after 2 of 4 words → next cycle all outputs 0 and no DONE pulse. RQ still high → re-granted one cycle after RESET deasserts, restarting at word 0.
- WDS=0000 write plus a stray ACKN_PULSE while idle → the stray pulse is ignored. The transaction runs as a one-word mask 1000, MB_SEL=0, with a single WORD_ACK.

Source files
------------

// File: rtl/mbox_mem_rq_arb.sv
// Memory request arbiter and sequencer for the MBOX S-bus port.
// Arbitrates CHAN > CCA > EBOX onto the single memory port, issues the
// start/read/write request with the word mask, counts ACKN word by word,
// and runs the NXM timeout that fabricates the remaining acknowledgements.
module mbox_mem_rq_arb #(
    parameter int unsigned NXM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [0:2]  RQ,
    input  logic [0:2]  RQ_RD,
    input  logic [0:11] RQ_WDS,
    input  logic        ACKN_PULSE,
    input  logic        NXM_ERR_CLR,
    output logic [0:2]  GRANT,
    output logic        MEM_START,
    output logic        MEM_RD_RQ,
    output logic        MEM_WR_RQ,
    output logic [0:3]  MEM_WDS,
    output logic [0:1]  MB_SEL,
    output logic        WORD_ACK,
    output logic        NXM_DATA_VAL,
    output logic        CORE_BUSY,
    output logic        NXM_FLG,
    output logic        NXM_ERR,
    output logic [0:2]  DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_NXM,
        S_FIN
    } state_t;

    // Timeout fires on the edge where the counter would reach NXM_TIMEOUT,
    // so NXM_FLG rises exactly NXM_TIMEOUT cycles after entering WAIT.
    localparam logic [7:0] TO_LAST = 8'(NXM_TIMEOUT - 1);

    state_t     state;
    logic [0:3] rem;
    logic [7:0] cnt;

    logic [0:2] win_gnt;
    logic       win_rd;
    logic [0:3] win_wds;
    logic [0:3] rem_after;
    logic [1:0] next_sel;

    // Index of the lowest-numbered set word in a mask (word 0 first).
    function automatic logic [1:0] low_idx(input logic [0:3] m);
        logic [1:0] idx;
        logic       found;
        idx   = 2'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (m[i] && !found) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Fixed-priority winner selection; an empty mask means word 0 only.
    always_comb begin
        win_gnt = '0;
        win_rd  = 1'b0;
        win_wds = '0;
        if (RQ[0]) begin
            win_gnt = 3'b100;
            win_rd  = RQ_RD[0];
            win_wds = RQ_WDS[0:3];
        end else if (RQ[1]) begin
            win_gnt = 3'b010;
            win_rd  = RQ_RD[1];
            win_wds = RQ_WDS[4:7];
        end else if (RQ[2]) begin
            win_gnt = 3'b001;
            win_rd  = RQ_RD[2];
            win_wds = RQ_WDS[8:11];
        end
        if (win_wds == '0) begin
            win_wds = 4'b1000;
        end
    end

    // Remaining mask and next word select once the current word retires.
    always_comb begin
        rem_after         = rem;
        rem_after[MB_SEL] = 1'b0;
        next_sel          = (rem_after == '0) ? MB_SEL : low_idx(rem_after);
    end

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state        <= S_IDLE;
            rem          <= '0;
            cnt          <= '0;
            GRANT        <= '0;
            MEM_START    <= 1'b0;
            MEM_RD_RQ    <= 1'b0;
            MEM_WR_RQ    <= 1'b0;
            MEM_WDS      <= '0;
            MB_SEL       <= '0;
            WORD_ACK     <= 1'b0;
            NXM_DATA_VAL <= 1'b0;
            CORE_BUSY    <= 1'b0;
            NXM_FLG      <= 1'b0;
            NXM_ERR      <= 1'b0;
            DONE         <= '0;
        end else begin
            WORD_ACK     <= 1'b0;
            NXM_DATA_VAL <= 1'b0;
            DONE         <= '0;
            if (NXM_ERR_CLR) begin
                NXM_ERR <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (|RQ) begin
                        GRANT     <= win_gnt;
                        MEM_START <= 1'b1;
                        MEM_RD_RQ <= win_rd;
                        MEM_WR_RQ <= !win_rd;
                        MEM_WDS   <= win_wds;
                        rem       <= win_wds;
                        MB_SEL    <= low_idx(win_wds);
                        CORE_BUSY <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Empty mask here means the last WORD_ACK is out now.
                    if (rem == '0) begin
                        DONE  <= GRANT;
                        state <= S_FIN;
                    end else if (ACKN_PULSE) begin
                        WORD_ACK  <= 1'b1;
                        rem       <= rem_after;
                        MB_SEL    <= next_sel;
                        MEM_START <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt == TO_LAST) begin
                        MEM_START <= 1'b0;
                        NXM_FLG   <= 1'b1;
                        NXM_ERR   <= 1'b1;
                        state     <= S_NXM;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_NXM: begin
                    if (rem == '0) begin
                        DONE    <= GRANT;
                        NXM_FLG <= 1'b0;
                        state   <= S_FIN;
                    end else begin
                        WORD_ACK     <= 1'b1;
                        NXM_DATA_VAL <= MEM_RD_RQ;
                        rem          <= rem_after;
                        MB_SEL       <= next_sel;
                    end
                end
                S_FIN: begin
                    GRANT     <= '0;
                    CORE_BUSY <= 1'b0;
                    MEM_RD_RQ <= 1'b0;
                    MEM_WR_RQ <= 1'b0;
                    MEM_WDS   <= '0;
                    MB_SEL    <= '0;
                    cnt       <= '0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbox_mem_rq_arb.sv
// Directed bench for mbox_mem_rq_arb with hand-computed expectations.
module tb_mbox_mem_rq_arb;

    logic        clk = 1'b0;
    logic        RESET;
    logic [0:2]  RQ;
    logic [0:2]  RQ_RD;
    logic [0:11] RQ_WDS;
    logic        ACKN_PULSE;
    logic        NXM_ERR_CLR;
    logic [0:2]  GRANT;
    logic        MEM_START;
    logic        MEM_RD_RQ;
    logic        MEM_WR_RQ;
    logic [0:3]  MEM_WDS;
    logic [0:1]  MB_SEL;
    logic        WORD_ACK;
    logic        NXM_DATA_VAL;
    logic        CORE_BUSY;
    logic        NXM_FLG;
    logic        NXM_ERR;
    logic [0:2]  DONE;

    int total = 0;
    int bad   = 0;

    mbox_mem_rq_arb #(.NXM_TIMEOUT(8)) dut (
        .clk          (clk),
        .RESET        (RESET),
        .RQ           (RQ),
        .RQ_RD        (RQ_RD),
        .RQ_WDS       (RQ_WDS),
        .ACKN_PULSE   (ACKN_PULSE),
        .NXM_ERR_CLR  (NXM_ERR_CLR),
        .GRANT        (GRANT),
        .MEM_START    (MEM_START),
        .MEM_RD_RQ    (MEM_RD_RQ),
        .MEM_WR_RQ    (MEM_WR_RQ),
        .MEM_WDS      (MEM_WDS),
        .MB_SEL       (MB_SEL),
        .WORD_ACK     (WORD_ACK),
        .NXM_DATA_VAL (NXM_DATA_VAL),
        .CORE_BUSY    (CORE_BUSY),
        .NXM_FLG      (NXM_FLG),
        .NXM_ERR      (NXM_ERR),
        .DONE         (DONE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Check the expected word select, pulse ACKN for one cycle, expect WORD_ACK.
    task automatic do_ack(input string tag, input logic [1:0] sel);
        chk({tag, "_sel"}, 32'(MB_SEL), 32'(sel));
        ACKN_PULSE = 1'b1;
        tick();
        ACKN_PULSE = 1'b0;
        chk({tag, "_wack"}, 32'(WORD_ACK), 32'd1);
    endtask

    function automatic logic [19:0] outs();
        return {GRANT, MEM_START, MEM_RD_RQ, MEM_WR_RQ, MEM_WDS, MB_SEL,
                WORD_ACK, NXM_DATA_VAL, CORE_BUSY, NXM_FLG, NXM_ERR, DONE};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        RESET = 1'b1; RQ = '0; RQ_RD = '0; RQ_WDS = '0;
        ACKN_PULSE = 1'b0; NXM_ERR_CLR = 1'b0;
        repeat (3) tick();
        chk("rst_outs", 32'(outs()), 32'd0);
        RESET = 1'b0;
        tick();

        // 1: EBOX read of all four words, ACKN every third cycle
        RQ = 3'b001; RQ_RD = 3'b001; RQ_WDS = 12'h00F;
        tick();
        chk("t1_gnt",   32'(GRANT), 32'b001);
        chk("t1_start", 32'(MEM_START), 32'd1);
        chk("t1_rd",    32'(MEM_RD_RQ), 32'd1);
        chk("t1_wds",   32'(MEM_WDS), 32'b1111);
        chk("t1_busy",  32'(CORE_BUSY), 32'd1);
        tick(); chk("t1_ms2", 32'(MEM_START), 32'd1);
        tick(); chk("t1_ms3", 32'(MEM_START), 32'd1);
        tick();
        do_ack("t1_w0", 2'd0);
        chk("t1_msdrop", 32'(MEM_START), 32'd0);
        for (int w = 1; w < 4; w++) begin
            tick(); tick();
            do_ack("t1_w", 2'(w));
        end
        chk("t1_nodone", 32'(DONE), 32'd0);
        tick();
        chk("t1_done",  32'(DONE), 32'b001);
        chk("t1_busy2", 32'(CORE_BUSY), 32'd1);
        chk("t1_nxm",   32'(NXM_ERR), 32'd0);
        RQ = '0;
        tick();
        chk("t1_idle", 32'({GRANT, CORE_BUSY, DONE}), 32'd0);

        // 2: CHAN write 0101 and EBOX read collide; CHAN wins
        RQ = 3'b101; RQ_RD = 3'b001; RQ_WDS = {4'b0101, 4'b0000, 4'b1111};
        tick();
        chk("t2_gnt", 32'(GRANT), 32'b100);
        chk("t2_wr",  32'(MEM_WR_RQ), 32'd1);
        chk("t2_rd",  32'(MEM_RD_RQ), 32'd0);
        tick();
        do_ack("t2_a", 2'd1);
        chk("t2_sel3", 32'(MB_SEL), 32'd3);
        do_ack("t2_b", 2'd3);
        tick();
        chk("t2_done", 32'(DONE), 32'b100);
        RQ = 3'b001;
        tick();
        chk("t2_gap", 32'(GRANT), 32'd0);
        tick();
        chk("t2_gnt2", 32'(GRANT), 32'b001);
        chk("t2_sel0", 32'(MB_SEL), 32'd0);
        chk("t2_rd2",  32'(MEM_RD_RQ), 32'd1);
        tick();
        for (int w = 0; w < 4; w++) do_ack("t2_e", 2'(w));
        tick();
        chk("t2_done2", 32'(DONE), 32'b001);
        RQ = '0;
        tick();

        // 3: CCA read 0011, memory never answers
        RQ = 3'b010; RQ_RD = 3'b010; RQ_WDS = {4'b0000, 4'b0011, 4'b0000};
        tick();
        chk("t3_gnt", 32'(GRANT), 32'b010);
        chk("t3_sel", 32'(MB_SEL), 32'd2);
        tick();
        repeat (7) tick();
        chk("t3_noflg", 32'(NXM_FLG), 32'd0);
        chk("t3_ms",    32'(MEM_START), 32'd1);
        tick();
        chk("t3_flg",   32'(NXM_FLG), 32'd1);
        chk("t3_err",   32'(NXM_ERR), 32'd1);
        chk("t3_msoff", 32'(MEM_START), 32'd0);
        chk("t3_sel2",  32'(MB_SEL), 32'd2);
        chk("t3_wack0", 32'(WORD_ACK), 32'd0);
        ACKN_PULSE = 1'b1;
        tick();
        ACKN_PULSE = 1'b0;
        chk("t3_wack1", 32'(WORD_ACK), 32'd1);
        chk("t3_dv1",   32'(NXM_DATA_VAL), 32'd1);
        chk("t3_sel3",  32'(MB_SEL), 32'd3);
        tick();
        chk("t3_wack2", 32'(WORD_ACK), 32'd1);
        chk("t3_dv2",   32'(NXM_DATA_VAL), 32'd1);
        tick();
        chk("t3_done",  32'(DONE), 32'b010);
        chk("t3_wack3", 32'(WORD_ACK), 32'd0);
        chk("t3_flgoff", 32'(NXM_FLG), 32'd0);
        RQ = '0;
        tick();
        chk("t3_sticky", 32'(NXM_ERR), 32'd1);
        NXM_ERR_CLR = 1'b1;
        tick();
        NXM_ERR_CLR = 1'b0;
        chk("t3_clr", 32'(NXM_ERR), 32'd0);

        // 4: ACKN on the timeout cycle wins and restarts the counter
        RQ = 3'b001; RQ_RD = 3'b000; RQ_WDS = 12'h00C;
        tick(); tick();
        repeat (7) tick();
        chk("t4_pre", 32'(NXM_FLG), 32'd0);
        do_ack("t4_hit", 2'd0);
        chk("t4_noflg", 32'(NXM_FLG), 32'd0);
        repeat (7) tick();
        chk("t4_restart", 32'(NXM_FLG), 32'd0);
        tick();
        chk("t4_flg", 32'(NXM_FLG), 32'd1);
        tick();
        chk("t4_wack", 32'(WORD_ACK), 32'd1);
        chk("t4_dv",   32'(NXM_DATA_VAL), 32'd0);
        tick();
        chk("t4_done", 32'(DONE), 32'b001);
        RQ = '0;
        tick();

        // 5: reset in WAIT after two of four words
        RQ = 3'b100; RQ_RD = 3'b100; RQ_WDS = 12'hF00;
        tick();
        chk("t5_gnt", 32'(GRANT), 32'b100);
        tick();
        do_ack("t5_w0", 2'd0);
        do_ack("t5_w1", 2'd1);
        chk("t5_errset", 32'(NXM_ERR), 32'd1);
        RESET = 1'b1;
        tick();
        chk("t5_rst", 32'(outs()), 32'd0);
        RESET = 1'b0;
        tick();
        chk("t5_regnt", 32'(GRANT), 32'b100);
        chk("t5_sel",   32'(MB_SEL), 32'd0);
        chk("t5_ms",    32'(MEM_START), 32'd1);
        chk("t5_nodone", 32'(DONE), 32'd0);
        tick();
        for (int w = 0; w < 4; w++) do_ack("t5_r", 2'(w));
        tick();
        chk("t5_done", 32'(DONE), 32'b100);
        RQ = '0;
        tick();

        // 6: stray ACKN while idle, then an empty-mask write
        ACKN_PULSE = 1'b1;
        tick();
        ACKN_PULSE = 1'b0;
        chk("t6_stray", 32'(outs()), 32'd0);
        RQ = 3'b001; RQ_RD = 3'b000; RQ_WDS = 12'h000;
        tick();
        chk("t6_gnt", 32'(GRANT), 32'b001);
        chk("t6_wds", 32'(MEM_WDS), 32'b1000);
        chk("t6_sel", 32'(MB_SEL), 32'd0);
        chk("t6_wr",  32'(MEM_WR_RQ), 32'd1);
        ACKN_PULSE = 1'b1;
        tick();
        ACKN_PULSE = 1'b0;
        chk("t6_startign", 32'(WORD_ACK), 32'd0);
        chk("t6_ms",       32'(MEM_START), 32'd1);
        tick();
        do_ack("t6_w0", 2'd0);
        tick();
        chk("t6_single", 32'(WORD_ACK), 32'd0);
        chk("t6_done",   32'(DONE), 32'b001);
        RQ = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
